shift_add_mult_ctrl: RTL

Sequencer for the shift-add multiplier datapath. It accepts one pair of unsigned operands over a valid/ready handshake. It then runs WIDTH add/shift iterations on a (2*WIDTH+1)-bit accumulator, adding the multiplicand into the accumulator's upper half whenever the accumulator LSB is 1. It presents the 2*WIDTH-bit product over a second valid/ready handshake. It is the control and sequencing wrapper that time-multiplexes a single upper-half adder over the iterations.

---
 rtl/shift_add_mult_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Shift-add multiplier sequencer: one shared upper-half adder reused over
// WIDTH add/shift iterations, with valid/ready handshakes on both sides.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // State and datapath registers; reset clears everything, aborting any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: capture, conditional add, shift, hold.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d   = {1'b0, {WIDTH{1'b0}}, in_b};
                    mcand_d = in_a;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (acc_q[0]) begin
                    acc_d[2*WIDTH:WIDTH] = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                                         + {1'b0, mcand_q};
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                acc_d = acc_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign out_product = acc_q[2*WIDTH-1:0];

endmodule
